fetch_pc_sequencer: RTL and testbench
=====================================

# fetch_pc_sequencer

Fetch-stage PC sequencer sitting in front of the instruction cache. Owns the fetch PC: it steps sequentially by 4 and accepts branch/jump redirects carried by `PCSrc`/`PCTarget` from execute. It runs a single-outstanding request/ready handshake with the I-cache. It holds the fetched instruction and its PC for decode until decode stops stalling.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, value driven on `InstrF` when no valid instruction is held

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `PCSrc`  in  1  redirect request from execute (one-cycle pulse per taken branch/jump)
- `PCTarget`  in  32  redirect address, sampled when `PCSrc`=1
- `StallF`  in  1  decode cannot accept; hold current instruction
- `ICacheReq`  out  1  fetch request to I-cache
- `ICacheAddr`  out  32  fetch address; stable while `ICacheReq`=1 until `ICacheReady`
- `ICacheReady`  in  1  one-cycle completion; `ICacheInstr` valid this cycle
- `ICacheInstr`  in  32  fetched word
- `InstrF`  out  32  held instruction
- `InstrValidF`  out  1  `InstrF`/`PCF` valid
- `PCF`  out  32  address of `InstrF`
- `PCPlus4F`  out  32  `PCF`+4, combinational

## Operation
- Registers:
  - `FetchPC`: next address to fetch.
  - `PCF`, `InstrF`.
  - `RedirPend`/`RedirPC`: buffered redirect.
  - 2-state FSM: `S_FETCH`, `S_VALID`.
- `ICacheAddr` = `FetchPC`. `ICacheReq` = 1 only in `S_FETCH`.
- `S_FETCH`, the request is outstanding:
  - `ICacheReady`=0, `PCSrc`=1: `RedirPend`<=1 and `RedirPC`<=`PCTarget`. The latest redirect overwrites an older one. `FetchPC` does not change, so the address stays stable.
  - `ICacheReady`=1 with `PCSrc`=1 or `RedirPend`=1: discard the returned word. `FetchPC`<=`PCTarget` if `PCSrc`, else `RedirPC`. Clear `RedirPend`. Remain in `S_FETCH`.
  - `ICacheReady`=1 with no redirect: `InstrF`<=`ICacheInstr`, `PCF`<=`FetchPC`, `FetchPC`<=`FetchPC`+4, go to `S_VALID`.
- `S_VALID`:
  - `PCSrc`=1: flush the held instruction (`InstrValidF`<=0, `InstrF`<=`NOP_INSTR`), `FetchPC`<=`PCTarget`, go to `S_FETCH`. Redirect has priority over `StallF`.
  - `StallF`=1: hold all state.
  - `StallF`=0: the instruction is consumed. Clear valid, go to `S_FETCH`.
- Arithmetic: all adds are 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `PCTarget[1:0]` handling: see Configuration.

## Timing
- Reset (async assert):
  - `FetchPC`=`RESET_PC`, `PCF`=`RESET_PC`, `InstrF`=`NOP_INSTR`.
  - `InstrValidF`=0, `RedirPend`=0, FSM=`S_FETCH`.
  - `ICacheReq` is 0 while `rst_n`=0 and 1 from the first cycle after deassertion.
- Reset mid-request abandons the transaction. The I-cache must drop it when it sees `ICacheReq` low.
- Latency:
  - A cache hit with `ICacheReady` in the same cycle as the request gives `InstrValidF`=1 on the next cycle.
  - Peak throughput is one instruction per 2 cycles.
- A redirect in `S_VALID` issues the target request on the next cycle.
- A redirect during an outstanding miss takes effect on the cycle after `ICacheReady`. No stale instruction ever reaches `InstrValidF`.
- `PCPlus4F` tracks `PCF` with zero latency.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - Adds output `MisalignF` (1 bit, reset 0).
  - A redirect with `PCTarget[1:0]`≠0 is ignored; no state change from it.
  - `MisalignF` pulses high for exactly one cycle, the cycle after `PCSrc`.
- Undefined:
  - No port.
  - `PCTarget[1:0]` is forced to 2'b00 and the redirect is taken.

## Test plan
- Reset release, cache returns `ICacheReady` same cycle with 0x00500093 → `InstrValidF`=1, `PCF`=0x0, `InstrF`=0x00500093. The next request goes to 0x4.
- `StallF`=1 for 3 cycles in `S_VALID` → `InstrF`/`PCF` held and `ICacheReq`=0. Release → request goes to `PCF`+4.
- `ICacheReady` delayed 5 cycles; `PCSrc` pulses with `PCTarget`=0x100 at cycle 2 → `ICacheAddr` stays 0x4 until ready. The returned word is discarded and the next request goes to 0x100.
- `PCSrc`=1 (target 0x200) with `StallF`=1 in `S_VALID` → held instruction flushed (`InstrValidF`=0, `InstrF`=0x00000013) and the next request goes to 0x200.
- Sequential fetch from `RESET_PC`=0xFFFF_FFFC → the next fetch address wraps to 0x0000_0000.
- Redirect to 0x102 → with the macro: ignored, `MisalignF` pulses once. Without: the request goes to 0x100. Also assert `rst_n` low mid-miss → all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC in front of the I-cache.
// Steps sequentially by 4 and accepts redirects from execute. Keeps a single
// request outstanding to the I-cache, and holds the fetched word and its PC
// for decode until decode stops stalling.
// Optional build macro: FETCH_MISALIGN_CHK_EN. When defined, misaligned
// redirect targets are dropped and reported on MisalignF. When undefined,
// the low two target bits are cleared and the redirect is taken.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        StallF,
    output logic        ICacheReq,
    output logic [31:0] ICacheAddr,
    input  logic        ICacheReady,
    input  logic [31:0] ICacheInstr,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        MisalignF
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    // Qualified redirect: whether this cycle's PCSrc counts, and where it goes
    logic        redir_take;
    logic [31:0] redir_tgt;

    // Sequential PC step; wraps modulo 2^32
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    // A misaligned target is dropped entirely and flagged one cycle later
    always_comb begin
        redir_take = PCSrc && (PCTarget[1:0] == 2'b00);
        redir_tgt  = PCTarget;
        misalign_d = PCSrc && (PCTarget[1:0] != 2'b00);
    end

    // Misalignment flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign MisalignF = misalign_q;
`else
    // Low target bits are cleared so every redirect lands word-aligned
    always_comb begin
        redir_take = PCSrc;
        redir_tgt  = PCTarget & ~32'h0000_0003;
    end
`endif

    // State and datapath registers; async reset abandons any open request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            pcf_q        <= RESET_PC;
            instr_q      <= NOP_INSTR;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pcf_q        <= pcf_d;
            instr_q      <= instr_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    // Next-state logic: request handshake, redirect buffering, decode hold
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pcf_d        = pcf_q;
        instr_d      = instr_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;

        case (state_q)
            S_FETCH: begin
                if (ICacheReady) begin
                    if (redir_take || redir_pend_q) begin
                        // Returned word belongs to the wrong path: drop it
                        fetch_pc_d   = redir_take ? redir_tgt : redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d    = ICacheInstr;
                        pcf_d      = fetch_pc_q;
                        fetch_pc_d = pc_add4(fetch_pc_q);
                        state_d    = S_VALID;
                    end
                end else if (redir_take) begin
                    // Address must stay stable while the miss is open, so
                    // park the redirect; a newer one replaces an older one
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redir_tgt;
                end
            end
            S_VALID: begin
                if (redir_take) begin
                    // Redirect wins over stall: flush the held instruction
                    instr_d    = NOP_INSTR;
                    fetch_pc_d = redir_tgt;
                    state_d    = S_FETCH;
                end else if (!StallF) begin
                    instr_d = NOP_INSTR;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs; the request is gated by reset so it is low while rst_n is low
    assign ICacheReq   = rst_n && (state_q == S_FETCH);
    assign ICacheAddr  = fetch_pc_q;
    assign InstrF      = instr_q;
    assign InstrValidF = (state_q == S_VALID);
    assign PCF         = pcf_q;
    assign PCPlus4F    = pc_add4(pcf_q);

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: reset, hit, stall, miss with
// redirect, flush under stall, PC wrap, misaligned redirect, mid-miss reset.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        StallF;
    logic        ICacheReady;
    logic [31:0] ICacheInstr;

    logic        req, req_w;
    logic [31:0] addr, addr_w;
    logic [31:0] instr, instr_w;
    logic        vld, vld_w;
    logic [31:0] pcf, pcf_w;
    logic [31:0] pc4, pc4_w;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        mis, mis_w;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .StallF(StallF), .ICacheReq(req), .ICacheAddr(addr),
        .ICacheReady(ICacheReady), .ICacheInstr(ICacheInstr),
        .InstrF(instr), .InstrValidF(vld), .PCF(pcf), .PCPlus4F(pc4)
`ifdef FETCH_MISALIGN_CHK_EN
        , .MisalignF(mis)
`endif
    );

    // Second instance starting at the top of the address space
    fetch_pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .StallF(StallF), .ICacheReq(req_w), .ICacheAddr(addr_w),
        .ICacheReady(ICacheReady), .ICacheInstr(ICacheInstr),
        .InstrF(instr_w), .InstrValidF(vld_w), .PCF(pcf_w), .PCPlus4F(pc4_w)
`ifdef FETCH_MISALIGN_CHK_EN
        , .MisalignF(mis_w)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; StallF = 1'b0;
        ICacheReady = 1'b0; ICacheInstr = '0;
        step(2);

        // Reset state
        chk("rst_req",   {31'd0, req}, 32'd0);
        chk("rst_vld",   {31'd0, vld}, 32'd0);
        chk("rst_pcf",   pcf, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_addr",  addr, 32'h0);
        chk("rst_pc4",   pc4, 32'h4);
        chk("rst_addr_w", addr_w, 32'hFFFF_FFFC);

        // Release reset; same-cycle hit
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'd0, req}, 32'd1);
        ICacheReady = 1'b1; ICacheInstr = 32'h0050_0093;
        step();
        ICacheReady = 1'b0;
        chk("hit_vld",   {31'd0, vld}, 32'd1);
        chk("hit_pcf",   pcf, 32'h0);
        chk("hit_instr", instr, 32'h0050_0093);
        chk("hit_pc4",   pc4, 32'h4);
        chk("hit_req",   {31'd0, req}, 32'd0);
        chk("hit_addr",  addr, 32'h4);
        chk("wrap_pcf",  pcf_w, 32'hFFFF_FFFC);
        chk("wrap_pc4",  pc4_w, 32'h0);
        chk("wrap_addr", addr_w, 32'h0);

        // Stall for three cycles
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_vld",   {31'd0, vld}, 32'd1);
            chk("stall_instr", instr, 32'h0050_0093);
            chk("stall_pcf",   pcf, 32'h0);
            chk("stall_req",   {31'd0, req}, 32'd0);
        end
        StallF = 1'b0;
        step();
        chk("cons_vld",   {31'd0, vld}, 32'd0);
        chk("cons_req",   {31'd0, req}, 32'd1);
        chk("cons_addr",  addr, 32'h4);
        chk("cons_instr", instr, 32'h0000_0013);
        chk("wrap_addr2", addr_w, 32'h0);

        // Miss at 0x4 with redirect to 0x100 arriving mid-miss
        step();
        chk("miss_addr1", addr, 32'h4);
        PCSrc = 1'b1; PCTarget = 32'h100;
        step();
        PCSrc = 1'b0;
        chk("miss_addr2", addr, 32'h4);
        chk("miss_req2",  {31'd0, req}, 32'd1);
        step(2);
        chk("miss_addr4", addr, 32'h4);
        ICacheReady = 1'b1; ICacheInstr = 32'hDEAD_BEEF;
        step();
        ICacheReady = 1'b0;
        chk("disc_vld",   {31'd0, vld}, 32'd0);
        chk("disc_instr", instr, 32'h0000_0013);
        chk("disc_req",   {31'd0, req}, 32'd1);
        chk("disc_addr",  addr, 32'h100);

        // Hit at 0x100, then redirect to 0x200 under stall
        ICacheReady = 1'b1; ICacheInstr = 32'h00A0_0113;
        step();
        ICacheReady = 1'b0;
        chk("h100_vld", {31'd0, vld}, 32'd1);
        chk("h100_pcf", pcf, 32'h100);
        chk("h100_pc4", pc4, 32'h104);
        StallF = 1'b1; PCSrc = 1'b1; PCTarget = 32'h200;
        step();
        PCSrc = 1'b0; StallF = 1'b0;
        chk("flush_vld",   {31'd0, vld}, 32'd0);
        chk("flush_instr", instr, 32'h0000_0013);
        chk("flush_req",   {31'd0, req}, 32'd1);
        chk("flush_addr",  addr, 32'h200);

        // Redirect coinciding with ready: word dropped, jump to 0x300
        ICacheReady = 1'b1; ICacheInstr = 32'h1111_1111; PCSrc = 1'b1; PCTarget = 32'h300;
        step();
        ICacheReady = 1'b0; PCSrc = 1'b0;
        chk("rdy_redir_vld",  {31'd0, vld}, 32'd0);
        chk("rdy_redir_addr", addr, 32'h300);

        // Misaligned redirect to 0x102 during a miss at 0x300
        PCSrc = 1'b1; PCTarget = 32'h102;
        step();
        PCSrc = 1'b0;
        chk("mis_addr", addr, 32'h300);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_pulse", {31'd0, mis}, 32'd1);
        step();
        chk("mis_clear", {31'd0, mis}, 32'd0);
        ICacheReady = 1'b1; ICacheInstr = 32'h2222_2222;
        step();
        ICacheReady = 1'b0;
        chk("mis_keep_vld", {31'd0, vld}, 32'd1);
        chk("mis_keep_pcf", pcf, 32'h300);
        step();
        chk("mis_next_addr", addr, 32'h304);
`else
        step();
        ICacheReady = 1'b1; ICacheInstr = 32'h2222_2222;
        step();
        ICacheReady = 1'b0;
        chk("mis_take_vld",  {31'd0, vld}, 32'd0);
        chk("mis_take_addr", addr, 32'h100);
`endif

        // Miss with a pending redirect, then async reset mid-miss
        PCSrc = 1'b1; PCTarget = 32'h400;
        step();
        PCSrc = 1'b0;
        chk("pre_rst_req", {31'd0, req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'd0, req}, 32'd0);
        chk("arst_addr",  addr, 32'h0);
        chk("arst_pcf",   pcf, 32'h0);
        chk("arst_instr", instr, 32'h0000_0013);
        chk("arst_vld",   {31'd0, vld}, 32'd0);
        chk("arst_pc4",   pc4, 32'h4);
        step();
        rst_n = 1'b1;
        ICacheReady = 1'b1; ICacheInstr = 32'h0030_0193;
        step();
        ICacheReady = 1'b0;
        chk("post_rst_vld",   {31'd0, vld}, 32'd1);
        chk("post_rst_pcf",   pcf, 32'h0);
        chk("post_rst_instr", instr, 32'h0030_0193);
        chk("post_rst_addr",  addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
